noise_burst_ctrl: RTL and testbench

NOISE_BURST_CTRL -- requirements
Module: noise_burst_ctrl

---
 rtl/noise_burst_ctrl.sv | 86 ++++++++
 tb/tb_noise_burst_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/noise_burst_ctrl.sv
// noise_burst_ctrl: adds generator noise to a bounded burst of symbols.
// Define NOISE_BURST_SAT_EN for a saturating sum; otherwise the sum wraps.
module noise_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 16,
  parameter int WARMUP_MAX = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         burst_len,
  output logic                     noise_en,
  input  logic signed [DATA_W-1:0] noise_in,
  input  logic                     noise_in_valid,
  input  logic signed [DATA_W-1:0] sym_in,
  input  logic                     sym_in_valid,
  output logic                     sym_in_ready,
  output logic signed [DATA_W-1:0] sym_out,
  output logic                     sym_out_valid,
  input  logic                     sym_out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         sample_count
);
  localparam int WW = $clog2(WARMUP_MAX + 1);
  typedef enum logic [2:0] {IDLE, WARMUP, RUN, DRAIN, DONE} state_t;
  state_t state, next;
  logic [CNT_W-1:0] len;
  logic [WW-1:0] wcnt;
  logic xfer, wto, last;
  logic signed [DATA_W-1:0] res;
`ifdef NOISE_BURST_SAT_EN
  logic [DATA_W:0] sum;
  assign sum = {sym_in[DATA_W-1], sym_in} + {noise_in[DATA_W-1], noise_in};
  assign res = sum[DATA_W] == sum[DATA_W-1] ? sum[DATA_W-1:0] : {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}};
`else
  assign res = sym_in + noise_in;
`endif
  // abort wins over a same-cycle symbol so no new sample enters after it
  assign sym_in_ready = state == RUN && noise_in_valid && !abort && (!sym_out_valid || sym_out_ready);
  assign xfer = sym_in_valid && sym_in_ready;
  assign last = sample_count + CNT_W'(1) == len;
  assign wto = wcnt == WW'(WARMUP_MAX - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = burst_len == '0 ? DONE : WARMUP;
      WARMUP:  if (abort || (!noise_in_valid && wto)) next = DRAIN;
               else if (noise_in_valid) next = RUN;
      RUN:     if (abort || (xfer && last)) next = DRAIN;
      DRAIN:   if (!sym_out_valid || sym_out_ready) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      noise_en <= 1'b0;
      len <= '0;
      wcnt <= '0;
      sym_out <= '0;
      sym_out_valid <= 1'b0;
      timeout_err <= 1'b0;
      sample_count <= '0;
    end else begin
      state <= next;
      noise_en <= next == WARMUP || next == RUN;
      wcnt <= state == WARMUP ? wcnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        len <= burst_len;
        sample_count <= '0;
        timeout_err <= 1'b0;
      end
      if (state == WARMUP && !abort && !noise_in_valid && wto) timeout_err <= 1'b1;
      if (xfer) begin
        sym_out <= res;
        sym_out_valid <= 1'b1;
        sample_count <= sample_count + 1'b1;
      end else if (sym_out_ready) sym_out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_noise_burst_ctrl.sv
// tb_noise_burst_ctrl: directed and randomized bursts scored against a transaction-level model.
module tb_noise_burst_ctrl;
  localparam int DW = 8, CW = 16, WM = 64;
  localparam int LO = -(1 << (DW - 1)), HI = (1 << (DW - 1)) - 1;
`ifdef NOISE_BURST_SAT_EN
  localparam int SAT_EXP = 127;
`else
  localparam int SAT_EXP = -116;
`endif
  logic clk = 0, rst = 0, start = 0, abort = 0, noise_in_valid = 0, sym_in_valid = 0, sym_out_ready = 1;
  logic noise_en, sym_in_ready, sym_out_valid, busy, done, timeout_err;
  logic [CW-1:0] burst_len = '0, sample_count;
  logic signed [DW-1:0] noise_in = '0, sym_in = '0, sym_out, held;
  int vec = 0, bad = 0, delivered = 0, last_out = 0, fnoise = 0;
  int q[$], fsym[$];
  bit held_v = 0;
  noise_burst_ctrl #(.DATA_W(DW), .CNT_W(CW), .WARMUP_MAX(WM)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .burst_len(burst_len),
    .noise_en(noise_en), .noise_in(noise_in), .noise_in_valid(noise_in_valid),
    .sym_in(sym_in), .sym_in_valid(sym_in_valid), .sym_in_ready(sym_in_ready),
    .sym_out(sym_out), .sym_out_valid(sym_out_valid), .sym_out_ready(sym_out_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err), .sample_count(sample_count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int ref_sum(input int a, input int b);
    int s = a + b;
`ifdef NOISE_BURST_SAT_EN
    return s > HI ? HI : s < LO ? LO : s;
`else
    return ((s - LO) % (1 << DW) + (1 << DW)) % (1 << DW) + LO;
`endif
  endfunction
  // scoreboard: every accepted symbol must reappear once, in order, as symbol+noise
  always @(negedge clk) if (!rst) begin
    if (held_v) begin
      chk("hold_valid", sym_out_valid, 1);
      chk("hold_data", sym_out, held);
    end
    if (sym_out_valid && sym_out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("sym_out", sym_out, q.pop_front());
      last_out = int'(sym_out);
      delivered++;
    end
    held_v = sym_out_valid && !sym_out_ready;
    held = sym_out;
    chk("ready_rule", sym_in_ready && !(noise_en && noise_in_valid && (!sym_out_valid || sym_out_ready)), 0);
    if (sym_in_valid && sym_in_ready) q.push_back(ref_sum(int'(sym_in), int'(noise_in)));
  end
  task automatic rst_chk();
    chk("rst_noise_en", noise_en, 0);
    chk("rst_sym_in_ready", sym_in_ready, 0);
    chk("rst_sym_out", sym_out, 0);
    chk("rst_sym_out_valid", sym_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_sample_count", sample_count, 0);
  endtask
  task automatic burst(input int len, input int warm, input int pn, input int pr, input int psv,
                       input int abort_at, input int stall, input bit poke);
    int took, cyc, dn, ne, sl, ab_cyc, base, exp_n;
    bit tk, exp_to, fin;
    took = 0; cyc = 0; dn = 0; ne = 0; sl = -1; ab_cyc = -10; base = delivered; fin = 0;
    exp_to = len != 0 && warm >= WM && abort_at < 0;
    exp_n = abort_at >= 0 ? abort_at : exp_to ? 0 : len;
    @(posedge clk); #1; start = 1; burst_len = CW'(len);
    @(posedge clk); #1; start = 0; burst_len = CW'($urandom);
    while (!fin && cyc < 3000) begin
      noise_in_valid = cyc >= warm && $urandom_range(99) < pn;
      noise_in = fsym.size() > 0 ? DW'(fnoise) : DW'($urandom);
      sym_in_valid = $urandom_range(99) < psv;
      sym_in = took < fsym.size() ? DW'(fsym[took]) : DW'($urandom);
      sym_out_ready = sl > 0 ? 1'b0 : $urandom_range(99) < pr;
      abort = abort_at >= 0 && took == abort_at && ab_cyc < 0;
      if (abort) ab_cyc = cyc;
      start = poke && cyc == 1;
      if (start) burst_len = CW'(len + 3);
      @(negedge clk);
      tk = sym_in_valid && sym_in_ready;
      if (done) begin dn++; fin = 1; end
      if (noise_en) ne++;
      if (cyc == ab_cyc + 1) chk("abort_noise_en", noise_en, 0);
      if (tk) took++;
      if (sl > 0) sl--;
      if (stall > 0 && took == 1 && sl < 0) sl = stall;
      @(posedge clk); #1; cyc++;
    end
    noise_in_valid = 0; sym_in_valid = 0; sym_out_ready = 1; abort = 0; start = 0;
    repeat (3) begin @(negedge clk); if (done) dn++; end
    chk("cycle_budget", fin, 1);
    chk("done_pulses", dn, 1);
    chk("sample_count", sample_count, exp_n);
    chk("transfers", took, exp_n);
    chk("delivered", delivered - base, exp_n);
    chk("timeout_err", timeout_err, exp_to);
    chk("busy_idle", busy, 0);
    chk("out_valid_idle", sym_out_valid, 0);
    chk("queue_empty", q.size(), 0);
    if (exp_to) chk("warmup_cycles", ne, WM);
  endtask
  initial begin
    #1 rst = 1;
    #2 rst_chk();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    fsym = '{10, 20, 30, 40}; fnoise = 1;
    burst(4, 3, 100, 100, 100, -1, 0, 0);
    chk("last_of_four", last_out, 41);
    fsym = '{120}; fnoise = 20;
    burst(1, 0, 100, 100, 100, -1, 0, 0);
    chk("sum_limit", last_out, SAT_EXP);
    fsym = '{-100}; fnoise = -60;
    burst(1, 2, 100, 100, 100, -1, 0, 0);
    fsym.delete();
    burst(8, 1000, 0, 100, 100, -1, 0, 0);
    repeat (5) @(posedge clk);
    #1 chk("timeout_hold", timeout_err, 1);
    burst(0, 0, 100, 100, 100, -1, 0, 0);
    burst(3, 0, 100, 100, 100, -1, 5, 0);
    burst(10, 1, 100, 40, 100, 2, 0, 0);
    burst(5, 2, 80, 70, 90, -1, 0, 1);
    for (int i = 0; i < 25; i++) begin
      int l;
      l = $urandom_range(1, 12);
      burst(l, $urandom_range(0, 10), $urandom_range(50, 100), $urandom_range(30, 100),
            $urandom_range(30, 100), $urandom_range(3) == 0 ? int'($urandom_range(0, l - 1)) : -1,
            $urandom_range(3) == 0 ? int'($urandom_range(1, 6)) : 0, 1'($urandom_range(1)));
    end
    @(posedge clk); #1; start = 1; burst_len = 10; noise_in_valid = 1; sym_in_valid = 1;
    sym_out_ready = 0; sym_in = 5; noise_in = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_valid", sym_out_valid, 1);
    chk("pre_rst_noise_en", noise_en, 1);
    #2 rst = 1;
    q.delete();
    held_v = 0;
    #1 rst_chk();
    noise_in_valid = 0; sym_in_valid = 0; sym_out_ready = 1;
    @(posedge clk); #1 rst = 0;
    burst(6, 0, 90, 80, 90, -1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
